dice_roll_sequencer: RTL
========================

# dice_roll_sequencer

Controller that sequences the dice chain for a roll. On a debounced roll request it runs a timed tumble phase while the dice free-run. It then issues the `GET_NUM` freeze pulse to the addressed die and captures that die's value. It can do this for one die or sweep all seven dice, accumulating a total. It sits between the roll-button handler and the dice datapath, and feeds the display mux with `RESULT`, `TOTAL` and the `TUMBLE` animation flag.

## Interface
- `TUMBLE_CYCLES`, default 50_000_000: clock cycles per tumble phase; minimum 1.
- `DIE_WIDTH`, default 8: width of a die value.
- `NUM_DICE`, default 7: dice indices 0..NUM_DICE-1.
- `SUM_WIDTH`, default 10: accumulator width. 7×100 fits.
- `CLK`  in  1  system clock, rising edge.
- `RESET`  in  1  asynchronous, active-low reset.
- `ROLL`  in  1  one-cycle roll request, already debounced and edge-detected.
- `ROLL_ALL`  in  1  sampled with `ROLL`: 1 sweeps all dice, 0 rolls the die at `SEL`.
- `SEL`  in  3  die index for a single roll.
- `DIE_VAL`  in  DIE_WIDTH  value of the die addressed by `DIE_SEL`, from the external mux. Valid the cycle after `GET_NUM`.
- `GET_NUM`  out  1  one-cycle freeze/capture pulse to the dice.
- `DIE_SEL`  out  3  die currently being sequenced.
- `BUSY`  out  1  roll in progress.
- `TUMBLE`  out  1  tumble phase active; drives the display animation.
- `DONE`  out  1  one-cycle pulse when the roll completes.
- `RESULT`  out  DIE_WIDTH  last captured die value.
- `TOTAL`  out  SUM_WIDTH  sum of the values captured in the current/last roll.
- `ERR`  out  1  sticky error flag.

## Operation
- States: `IDLE`, `TUMBLE`, `FIRE`, `CAPTURE`.
- **IDLE**
  - `ROLL` is sampled here only.
  - If `ROLL_ALL`=0 and `SEL`≥NUM_DICE: the request is rejected. Set `ERR`, no `GET_NUM`, stay in IDLE.
  - Otherwise, on acceptance:
    - clear `ERR` and `TOTAL`;
    - `DIE_SEL` ← 0 for a sweep, else `SEL`;
    - load the tumble counter;
    - go to TUMBLE.
- **TUMBLE**
  - Hold for exactly TUMBLE_CYCLES cycles with `TUMBLE`=1, then go to FIRE.
- **FIRE**
  - `GET_NUM`=1 for this single cycle, then go to CAPTURE.
- **CAPTURE**
  - Register `DIE_VAL` into `RESULT` and add it to `TOTAL`.
  - Range check: a value of 0, or a value above `DIE_MAX_TABLE[DIE_SEL]`, sets `ERR`. The value is still captured.
  - Single roll, or sweep with `DIE_SEL`=NUM_DICE-1: pulse `DONE` and go to IDLE.
  - Otherwise: `DIE_SEL`+1, reload the counter, go to TUMBLE.
- `ROLL` while `BUSY`: ignored, with no queueing.
- `ROLL` is accepted in the same cycle `DONE` is high, because the state is already IDLE.
- `TOTAL` addition is unsigned. It saturates at 2^SUM_WIDTH−1 and does not wrap.
- Reset mid-operation aborts the roll immediately. No `GET_NUM` or `DONE` is emitted.
- Reset values:
  - `GET_NUM`, `BUSY`, `TUMBLE`, `DONE`, `ERR` = 0;
  - `DIE_SEL`, `RESULT`, `TOTAL` = 0;
  - state = IDLE.

## Timing
- All outputs are registered. E0 is the edge that samples an accepted `ROLL`.
- Per die:
  - `BUSY` and `TUMBLE` rise at E0.
  - `TUMBLE` stays high for T = TUMBLE_CYCLES cycles.
  - `GET_NUM` is high for the cycle after edge E0+T.
  - `DIE_VAL` is sampled at edge E0+T+2.
  - `RESULT`, `TOTAL` and `ERR` update at that same edge.
- Single roll: `DONE` is high and `BUSY` low from edge E0+T+2. Latency is T+2 cycles.
- Sweep: each die takes T+2 cycles, and the next `TUMBLE` starts at the capture edge. `DONE` arrives at E0+7(T+2). `BUSY` is continuous through the whole sweep.
- Rejected `ROLL`: `ERR` sets at E0; `BUSY` stays 0.

## Structure
- Shared package `dice_pkg`:
  - `NUM_DICE`;
  - `DIE_MAX_TABLE` = {20,12,10,10,8,6,4} for indices 0..6, matching the datapath's die order;
  - state encoding;
  - die-index type.
- Sub-module `tumble_timer`: loadable down-counter with `LOAD`, `EXPIRE`, and width $clog2(TUMBLE_CYCLES+1). The FSM, accumulator and range check stay in the top block.

## Test plan
- **Single roll:** TUMBLE_CYCLES=4, `SEL`=2, `DIE_VAL`=7, `ROLL` at E0 → `TUMBLE` high for 4 cycles, `GET_NUM` after edge E0+4, `DONE`/`RESULT`=7/`TOTAL`=7 at E0+6, `ERR`=0.
- **Sweep:** TUMBLE_CYCLES=4, `ROLL_ALL`=1, `DIE_VAL` per `DIE_SEL` = {15,3,9,1,8,6,4} → 7 `GET_NUM` pulses 6 cycles apart, `DIE_SEL` steps 0..6, `DONE` at E0+42, `TOTAL`=46, `RESULT`=4.
- **Busy/invalid requests:** `ROLL` pulses at E0+2 and E0+5 of a single roll → ignored, exactly one `DONE`. `ROLL` with `SEL`=7, `ROLL_ALL`=0 → `ERR`=1, no `BUSY`, no `GET_NUM`. The next valid `ROLL` clears `ERR`.
- **Range error:** `SEL`=1, `DIE_VAL`=13 → `RESULT`=13, `ERR`=1 at capture, `DONE` still pulses. With `DIE_VAL`=0 → same response.
- **Reset mid-operation:** `RESET` low during the 3rd die's `TUMBLE` of a sweep → all outputs 0 asynchronously. After release, no `GET_NUM`/`DONE` until a new `ROLL`. A new single roll then completes normally.
- **Back-to-back:** `ROLL` asserted in the `DONE` cycle → accepted. `BUSY` high again at the next edge, and the second `DONE` arrives T+2 cycles later.

Source files
------------

// File: rtl/dice_pkg.sv
// dice_pkg: shared dice constants, per-die maximum face values and FSM encoding.
package dice_pkg;
  localparam int NUM_DICE = 7;
  // Ordered to match the datapath's die chain (index 0 is the d20).
  localparam logic [31:0] DIE_MAX_TABLE [NUM_DICE] = '{32'd20, 32'd12, 32'd10, 32'd10, 32'd8, 32'd6, 32'd4};
  typedef enum logic [1:0] {S_IDLE, S_TUMBLE, S_FIRE, S_CAPTURE} state_e;
  typedef logic [2:0] die_idx_t;
  function automatic logic [31:0] die_max(input die_idx_t i);
    return (32'(i) < NUM_DICE) ? DIE_MAX_TABLE[i] : 32'd0;
  endfunction
endpackage

// File: rtl/tumble_timer.sv
// tumble_timer: loadable down-counter; expire_o marks the last cycle of a tumble phase.
module tumble_timer #(
  parameter int unsigned CYCLES = 50_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int W = $clog2(CYCLES + 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? W'(CYCLES) : (en_i && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign expire_o = cnt_q == W'(1);
endmodule

// File: rtl/dice_roll_sequencer.sv
// dice_roll_sequencer: sequences tumble, freeze and capture of one die or a sweep of all dice.
module dice_roll_sequencer #(
  parameter int unsigned TUMBLE_CYCLES = 50_000_000,
  parameter int DIE_WIDTH = 8,
  parameter int NUM_DICE  = 7,
  parameter int SUM_WIDTH = 10
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 roll_i,
  input  logic                 roll_all_i,
  input  logic [2:0]           sel_i,
  input  logic [DIE_WIDTH-1:0] die_val_i,
  output logic                 get_num_o,
  output logic [2:0]           die_sel_o,
  output logic                 busy_o,
  output logic                 tumble_o,
  output logic                 done_o,
  output logic [DIE_WIDTH-1:0] result_o,
  output logic [SUM_WIDTH-1:0] total_o,
  output logic                 err_o
);
  import dice_pkg::*;
  state_e               state_q, state_d;
  die_idx_t             die_sel_q, die_sel_d;
  logic                 sweep_q, sweep_d, busy_q, busy_d, tumble_q, tumble_d;
  logic                 get_num_q, get_num_d, done_q, done_d, err_q, err_d;
  logic [DIE_WIDTH-1:0] result_q, result_d;
  logic [SUM_WIDTH-1:0] total_q, total_d;
  logic [SUM_WIDTH:0]   sum;
  logic                 load, expire, bad_val, last_die;

  tumble_timer #(.CYCLES(TUMBLE_CYCLES)) u_timer (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .load_i   (load),
    .en_i     (state_q == S_TUMBLE),
    .expire_o (expire)
  );

  // One spare bit catches the carry so the total saturates instead of wrapping.
  assign sum      = {1'b0, total_q} + (SUM_WIDTH + 1)'(die_val_i);
  assign bad_val  = die_val_i == '0 || 32'(die_val_i) > die_max(die_sel_q);
  assign last_die = 32'(die_sel_q) == NUM_DICE - 1;

  always_comb begin
    state_d   = state_q;
    die_sel_d = die_sel_q;
    sweep_d   = sweep_q;
    busy_d    = busy_q;
    tumble_d  = tumble_q;
    get_num_d = 1'b0;
    done_d    = 1'b0;
    err_d     = err_q;
    result_d  = result_q;
    total_d   = total_q;
    load      = 1'b0;
    case (state_q)
      S_IDLE:
        if (roll_i) begin
          if (!roll_all_i && 32'(sel_i) >= NUM_DICE) begin
            err_d = 1'b1;
          end else begin
            err_d     = 1'b0;
            total_d   = '0;
            sweep_d   = roll_all_i;
            die_sel_d = roll_all_i ? '0 : sel_i;
            load      = 1'b1;
            busy_d    = 1'b1;
            tumble_d  = 1'b1;
            state_d   = S_TUMBLE;
          end
        end
      S_TUMBLE:
        if (expire) begin
          tumble_d  = 1'b0;
          get_num_d = 1'b1;
          state_d   = S_FIRE;
        end
      S_FIRE: state_d = S_CAPTURE;
      S_CAPTURE: begin
        result_d = die_val_i;
        total_d  = sum[SUM_WIDTH] ? '1 : sum[SUM_WIDTH-1:0];
        err_d    = err_q | bad_val;
        if (!sweep_q || last_die) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          die_sel_d = die_sel_q + 3'd1;
          load      = 1'b1;
          tumble_d  = 1'b1;
          state_d   = S_TUMBLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      die_sel_q <= '0;
      sweep_q   <= 1'b0;
      busy_q    <= 1'b0;
      tumble_q  <= 1'b0;
      get_num_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      result_q  <= '0;
      total_q   <= '0;
    end else begin
      state_q   <= state_d;
      die_sel_q <= die_sel_d;
      sweep_q   <= sweep_d;
      busy_q    <= busy_d;
      tumble_q  <= tumble_d;
      get_num_q <= get_num_d;
      done_q    <= done_d;
      err_q     <= err_d;
      result_q  <= result_d;
      total_q   <= total_d;
    end

  assign get_num_o = get_num_q;
  assign die_sel_o = die_sel_q;
  assign busy_o    = busy_q;
  assign tumble_o  = tumble_q;
  assign done_o    = done_q;
  assign result_o  = result_q;
  assign total_o   = total_q;
  assign err_o     = err_q;
endmodule
